dmem_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the single-port data memory. It sits between two requesters (port 0: core load/store unit; port 1: debug/DMA loader) and the memory's `m_addr`/`m_wr_dat`/`rd_en`/`wr_en`/`m_rd_dat` interface. It accepts one transaction at a time over valid/ready handshakes, drives the memory strobes for exactly one cycle, waits out the memory read latency, and returns a response to the owning port.

---
 rtl/dmem_arbiter_if.sv | 37 +++
 rtl/dmem_arbiter.sv | 101 ++++++++++
 tb/tb_dmem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Signal bundle for dmem_arbiter: two requester handshakes, the shared response
// bus and the single-port memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wr_dat;
    logic              rd_en;
    logic              wr_en;
    logic [DATA_W-1:0] m_rd_dat;

    modport slave (
        input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, m_rd_dat,
        output req_ready, rsp_valid, rsp_rdata, busy, m_addr, m_wr_dat, rd_en, wr_en
    );

    modport master (
        output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport mem (
        input  m_addr, m_wr_dat, rd_en, wr_en,
        output m_rd_dat
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer putting two requesters onto one data memory,
// one transaction at a time: IDLE -> ISSUE -> (WAIT) -> RESP.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input logic          clk,
    input logic          reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

    state_t            state;
    state_t            state_next;
    logic              last_grant;
    logic              grant;
    logic              take;
    logic              own_id;
    logic [1:0]        ready_c;
    logic [2:0]        lat_cnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [ADDR_W-1:0] m_addr_r;
    logic [DATA_W-1:0] m_wr_dat_r;
    logic              rd_en_r;
    logic              wr_en_r;
    logic [DATA_W-1:0] rsp_rdata_r;

    // Ready is gated by reset so a requester never sees an accept that reset discards.
    always_comb begin
        grant = 1'b0;
        case (bus.req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase

        ready_c = 2'b00;
        if (state == IDLE && !reset)
            ready_c[grant] = bus.req_valid[grant];
        take = |ready_c;

        sel_we    = bus.req_we[grant];
        sel_addr  = grant ? bus.req_addr1  : bus.req_addr0;
        sel_wdata = grant ? bus.req_wdata1 : bus.req_wdata0;

        state_next = state;
        case (state)
            IDLE:    if (take) state_next = ISSUE;
            ISSUE:   state_next = wr_en_r ? RESP : WAIT;
            WAIT:    if (lat_cnt <= 3'd1) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory strobes and address are loaded on the handshake edge so they are
    // registered and live exactly during ISSUE; everything else clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            own_id      <= 1'b0;
            lat_cnt     <= 3'd0;
            rd_en_r     <= 1'b0;
            wr_en_r     <= 1'b0;
            m_addr_r    <= '0;
            m_wr_dat_r  <= '0;
            rsp_rdata_r <= '0;
        end else begin
            state      <= state_next;
            rd_en_r    <= take & ~sel_we;
            wr_en_r    <= take & sel_we;
            m_addr_r   <= take ? sel_addr : '0;
            m_wr_dat_r <= (take && sel_we) ? sel_wdata : '0;
            if (take) begin
                own_id     <= grant;
                last_grant <= grant;
            end
            if (state == ISSUE)
                lat_cnt <= rd_en_r ? LAT_LOAD : 3'd0;
            else if (state == WAIT && lat_cnt != 3'd0)
                lat_cnt <= lat_cnt - 3'd1;
            rsp_rdata_r <= (state == WAIT && lat_cnt == 3'd1) ? bus.m_rd_dat : '0;
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = (state == RESP) ? (own_id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.busy      = (state != IDLE);
    assign bus.m_addr    = m_addr_r;
    assign bus.m_wr_dat  = m_wr_dat_r;
    assign bus.rd_en     = rd_en_r;
    assign bus.wr_en     = wr_en_r;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (RD_LAT 1, 3, 7) driven by directed and random
// requests and compared every cycle against a transaction-timing reference model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int N = 3;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  valid_d [N];
    logic [1:0]  we_d    [N];
    logic [31:0] addr_d  [N][2];
    logic [31:0] wdata_d [N][2];
    logic [31:0] rdat_d  [N];
    logic [1:0]  ready_o [N];
    logic [1:0]  rspv_o  [N];
    logic [31:0] rdata_o [N];
    logic [31:0] maddr_o [N];
    logic [31:0] mwdat_o [N];
    logic        rden_o  [N];
    logic        wren_o  [N];
    logic        busy_o  [N];

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : inst
            dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
            assign bus.req_valid  = valid_d[g];
            assign bus.req_we     = we_d[g];
            assign bus.req_addr0  = addr_d[g][0];
            assign bus.req_addr1  = addr_d[g][1];
            assign bus.req_wdata0 = wdata_d[g][0];
            assign bus.req_wdata1 = wdata_d[g][1];
            assign bus.m_rd_dat   = rdat_d[g];
            assign ready_o[g] = bus.req_ready;
            assign rspv_o[g]  = bus.rsp_valid;
            assign rdata_o[g] = bus.rsp_rdata;
            assign maddr_o[g] = bus.m_addr;
            assign mwdat_o[g] = bus.m_wr_dat;
            assign rden_o[g]  = bus.rd_en;
            assign wren_o[g]  = bus.wr_en;
            assign busy_o[g]  = bus.busy;

            dmem_arbiter #(
                .ADDR_W(32),
                .DATA_W(32),
                .RD_LAT((g == 0) ? 1 : ((g == 1) ? 3 : 7))
            ) dut (
                .clk  (clk),
                .reset(reset),
                .bus  (bus)
            );
        end
    endgenerate

    // Requester queues, held requests, and the reference model's view of each instance.
    req_t        reqq      [N][2][$];
    req_t        pend_req  [N][2];
    logic        pend      [N][2];
    int          txn_start [N];
    int          txn_port  [N];
    logic        txn_we    [N];
    logic [31:0] txn_addr  [N];
    logic [31:0] txn_data  [N];
    logic [31:0] txn_rdata [N];
    logic        last_grant[N];
    logic        exp_hs    [N];
    int          exp_grant [N];
    logic [31:0] ref_mem   [N][256];
    logic [31:0] dut_mem   [N][256];
    int          ret_cycle [N];
    logic [7:0]  ret_addr  [N];
    int          cyc;
    int          checks;
    int          errors;
    logic        rst_prev;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 7);
    endfunction

    function automatic int end_off(input int k);
        return txn_we[k] ? 2 : 2 + lat_of(k);
    endfunction

    task automatic check_output(input string tag, input int k, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s inst=%0d cyc=%0d observed=%h expected=%h", tag, k, cyc, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input int k);
        for (int p = 0; p < 2; p++) begin
            if (!pend[k][p] && reqq[k][p].size() > 0) begin
                pend_req[k][p] = reqq[k][p].pop_front();
                pend[k][p] = 1'b1;
            end
            we_d[k][p]    = pend[k][p] ? pend_req[k][p].we   : 1'($urandom_range(1));
            addr_d[k][p]  = pend[k][p] ? pend_req[k][p].addr : $urandom();
            wdata_d[k][p] = pend[k][p] ? pend_req[k][p].data : $urandom();
        end
        valid_d[k] = {pend[k][1], pend[k][0]};
        rdat_d[k]  = (cyc == ret_cycle[k]) ? dut_mem[k][ret_addr[k]] : $urandom();
    endtask

    // Expected outputs follow from cycle offsets relative to the handshake.
    task automatic check_cycle(input int k);
        logic        active;
        int          d;
        logic [1:0]  vals;
        logic        gr;
        logic [1:0]  e_ready;
        logic [1:0]  e_rspv;
        logic [31:0] e_rdata;
        active  = (txn_start[k] >= 0);
        d       = active ? cyc - txn_start[k] : 0;
        e_rspv  = (active && d == end_off(k)) ? ((txn_port[k] == 1) ? 2'b10 : 2'b01) : 2'b00;
        e_rdata = (e_rspv != 2'b00) ? txn_rdata[k] : 32'h0;
        vals    = {pend[k][1], pend[k][0]};
        gr      = (vals == 2'b10) ? 1'b1 : ((vals == 2'b11) ? ~last_grant[k] : 1'b0);
        e_ready = (active || vals == 2'b00) ? 2'b00 : (gr ? 2'b10 : 2'b01);
        exp_hs[k]    = (e_ready != 2'b00);
        exp_grant[k] = int'(gr);

        check_output("req_ready", k, 32'(ready_o[k]), 32'(e_ready));
        check_output("busy", k, 32'(busy_o[k]), 32'(active));
        check_output("rd_en", k, 32'(rden_o[k]), 32'(active && d == 1 && !txn_we[k]));
        check_output("wr_en", k, 32'(wren_o[k]), 32'(active && d == 1 && txn_we[k]));
        check_output("m_addr", k, maddr_o[k], (active && d == 1) ? txn_addr[k] : 32'h0);
        check_output("m_wr_dat", k, mwdat_o[k], (active && d == 1 && txn_we[k]) ? txn_data[k] : 32'h0);
        check_output("rsp_valid", k, 32'(rspv_o[k]), 32'(e_rspv));
        if (e_rspv != 2'b00 || rst_prev)
            check_output("rsp_rdata", k, rdata_o[k], e_rdata);

        if (wren_o[k] === 1'b1)
            dut_mem[k][maddr_o[k][7:0]] = mwdat_o[k];
        if (rden_o[k] === 1'b1) begin
            ret_cycle[k] = cyc + lat_of(k);
            ret_addr[k]  = maddr_o[k][7:0];
        end
    endtask

    task automatic edge_update(input int k);
        int gp;
        if (reset) begin
            txn_start[k]  = -1;
            last_grant[k] = 1'b1;
        end else begin
            if (txn_start[k] >= 0 && cyc - txn_start[k] >= end_off(k))
                txn_start[k] = -1;
            if (exp_hs[k]) begin
                gp = exp_grant[k];
                txn_start[k] = cyc;
                txn_port[k]  = gp;
                txn_we[k]    = pend_req[k][gp].we;
                txn_addr[k]  = pend_req[k][gp].addr;
                txn_data[k]  = pend_req[k][gp].data;
                txn_rdata[k] = txn_we[k] ? 32'h0 : ref_mem[k][txn_addr[k][7:0]];
                if (txn_we[k])
                    ref_mem[k][txn_addr[k][7:0]] = txn_data[k];
                last_grant[k] = gp[0];
                pend[k][gp]   = 1'b0;
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < N; k++) apply_stimulus(k);
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (!reset) check_cycle(k);
                else exp_hs[k] = 1'b0;
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) edge_update(k);
            rst_prev = reset;
            cyc++;
        end
    endtask

    task automatic push_all(input int p, input logic we, input logic [31:0] addr, input logic [31:0] data);
        req_t r;
        r.we = we;
        r.addr = addr;
        r.data = data;
        for (int k = 0; k < N; k++) reqq[k][p].push_back(r);
    endtask

    function automatic logic all_idle();
        logic idle;
        idle = 1'b1;
        for (int k = 0; k < N; k++)
            for (int p = 0; p < 2; p++)
                if (pend[k][p] || reqq[k][p].size() != 0 || txn_start[k] >= 0) idle = 1'b0;
        return idle;
    endfunction

    task automatic drain(input int budget);
        int used;
        used = 0;
        while (!all_idle() && used < budget) begin
            run_cycles(1);
            used++;
        end
        run_cycles(1);
    endtask

    initial begin
        logic [31:0] v;
        req_t r;
        checks = 0;
        errors = 0;
        cyc = 0;
        rst_prev = 1'b1;
        for (int k = 0; k < N; k++) begin
            for (int a = 0; a < 256; a++) begin
                v = $urandom();
                ref_mem[k][a] = v;
                dut_mem[k][a] = v;
            end
            pend[k][0] = 1'b0;
            pend[k][1] = 1'b0;
            txn_start[k] = -1;
            last_grant[k] = 1'b1;
            ret_cycle[k] = -1;
            exp_hs[k] = 1'b0;
        end

        @(posedge clk);
        #1;
        reset = 1'b1;
        run_cycles(3);
        reset = 1'b0;
        run_cycles(2);

        $display("[TB] single read");
        for (int k = 0; k < N; k++) begin
            ref_mem[k][8'h10] = 32'hDEADBEEF;
            dut_mem[k][8'h10] = 32'hDEADBEEF;
        end
        push_all(0, 1'b0, 32'h10, 32'h0);
        drain(40);

        $display("[TB] write then read");
        push_all(1, 1'b1, 32'h20, 32'hCAFEF00D);
        push_all(1, 1'b0, 32'h20, 32'h0);
        drain(40);

        $display("[TB] contention from reset");
        reset = 1'b1;
        run_cycles(1);
        reset = 1'b0;
        for (int j = 0; j < 2; j++) begin
            push_all(0, 1'b0, 32'h4, 32'h0);
            push_all(1, 1'b0, 32'h8, 32'h0);
        end
        drain(80);

        $display("[TB] single-port streaming");
        for (int j = 0; j < 4; j++) push_all(1, 1'b1, 32'h40 + 32'(j), $urandom());
        drain(40);

        $display("[TB] reset mid-read");
        push_all(0, 1'b0, 32'h30, 32'h0);
        run_cycles(2);
        reset = 1'b1;
        run_cycles(1);
        reset = 1'b0;
        run_cycles(1);
        push_all(0, 1'b0, 32'h4, 32'h0);
        push_all(1, 1'b0, 32'h8, 32'h0);
        drain(80);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++)
                for (int p = 0; p < 2; p++)
                    if (reqq[k][p].size() == 0 && $urandom_range(3) == 0) begin
                        r.we = 1'($urandom_range(1));
                        r.addr = $urandom();
                        r.data = $urandom();
                        reqq[k][p].push_back(r);
                    end
            reset = ($urandom_range(99) == 0);
            run_cycles(1);
        end
        reset = 1'b0;
        drain(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
